// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_controller
//  Description : Freeze/flush sequencer for the 5-stage pipeline. Combines
//                hazard, taken-branch and multi-cycle SRAM accesses into
//                per-register freeze/flush controls, runs the memory
//                wait-state FSM and keeps a saturating stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller #(
  parameter int MEM_WAIT_CYCLES = 4,
  parameter int STALL_CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hazard_detected,
  input  logic                   branch_taken,
  input  logic                   mem_r_en_mem,
  input  logic                   mem_w_en_mem,
  input  logic                   stall_cnt_clr,
  output logic                   pc_freeze,
  output logic                   if_id_freeze,
  output logic                   if_id_flush,
  output logic                   id_exe_freeze,
  output logic                   id_exe_flush,
  output logic                   exe_mem_freeze,
  output logic                   mem_wb_freeze,
  output logic                   sram_start,
  output logic                   mem_busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // The request cycle itself is the first frozen cycle, so ACCESS covers
  // the remaining MEM_WAIT_CYCLES-1 cycles.
  localparam logic [3:0] C_WAIT_LOAD = 4'(MEM_WAIT_CYCLES - 1);
  localparam logic [STALL_CNT_W-1:0] C_STALL_MAX = '1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [3:0]             r_wait_cnt;
  logic [3:0]             w_wait_nxt;
  logic                   w_mem_req;
  logic                   w_busy;
  logic                   w_start;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // State and wait counter registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Memory wait-state next-state logic; DONE ignores the still-present
  // request so the same instruction does not start a second access.
  always_comb begin
    w_mem_req   = mem_r_en_mem | mem_w_en_mem;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_busy      = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_req) begin
          w_start     = 1'b1;
          w_busy      = 1'b1;
          w_wait_nxt  = C_WAIT_LOAD;
          w_state_nxt = (MEM_WAIT_CYCLES == 1) ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_busy = 1'b1;
        if (r_wait_cnt == 4'd1) begin
          w_state_nxt = S_DONE;
        end else begin
          w_wait_nxt = r_wait_cnt - 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Prioritised freeze/flush outputs, all forced low while reset is held.
  always_comb begin
    pc_freeze      = 1'b0;
    if_id_freeze   = 1'b0;
    if_id_flush    = 1'b0;
    id_exe_freeze  = 1'b0;
    id_exe_flush   = 1'b0;
    exe_mem_freeze = 1'b0;
    mem_wb_freeze  = 1'b0;
    sram_start     = 1'b0;
    mem_busy       = 1'b0;
    stall_cnt      = '0;
    if (rst) begin
      sram_start = w_start;
      mem_busy   = w_busy;
      stall_cnt  = r_stall_cnt;
      if (w_busy) begin
        pc_freeze      = 1'b1;
        if_id_freeze   = 1'b1;
        id_exe_freeze  = 1'b1;
        exe_mem_freeze = 1'b1;
        mem_wb_freeze  = 1'b1;
      end else if (branch_taken) begin
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
      end else if (hazard_detected) begin
        pc_freeze    = 1'b1;
        if_id_freeze = 1'b1;
        id_exe_flush = 1'b1;
      end
    end
  end

  // Saturating count of PC-frozen cycles; clear takes precedence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (pc_freeze && (r_stall_cnt != C_STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_stall_controller
//  Description : Directed self-checking bench. Instance A uses the default
//                parameters; instance B uses MEM_WAIT_CYCLES=1 and a 4-bit
//                stall counter for saturation checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- instance A (defaults) ----------------
  logic a_rst, a_haz, a_br, a_mr, a_mw, a_clr;
  logic a_pc, a_ifz, a_iff, a_idz, a_idf, a_emz, a_mwz, a_start, a_busy;
  logic [15:0] a_cnt;
  logic [4:0]  a_frz;
  logic [1:0]  a_fl;
  logic [24:0] a_all;
  assign a_frz = {a_pc, a_ifz, a_idz, a_emz, a_mwz};
  assign a_fl  = {a_iff, a_idf};
  assign a_all = {a_frz, a_fl, a_start, a_busy, a_cnt};

  pipeline_stall_controller #(.MEM_WAIT_CYCLES(4), .STALL_CNT_W(16)) dut_a (
    .clk(clk), .rst(a_rst), .hazard_detected(a_haz), .branch_taken(a_br),
    .mem_r_en_mem(a_mr), .mem_w_en_mem(a_mw), .stall_cnt_clr(a_clr),
    .pc_freeze(a_pc), .if_id_freeze(a_ifz), .if_id_flush(a_iff),
    .id_exe_freeze(a_idz), .id_exe_flush(a_idf), .exe_mem_freeze(a_emz),
    .mem_wb_freeze(a_mwz), .sram_start(a_start), .mem_busy(a_busy),
    .stall_cnt(a_cnt)
  );

  // ---------------- instance B (MEM_WAIT_CYCLES=1, 4-bit counter) -------
  logic b_rst, b_haz, b_br, b_mr, b_mw, b_clr;
  logic b_pc, b_ifz, b_iff, b_idz, b_idf, b_emz, b_mwz, b_start, b_busy;
  logic [3:0]  b_cnt;
  logic [4:0]  b_frz;
  logic [12:0] b_all;
  assign b_frz = {b_pc, b_ifz, b_idz, b_emz, b_mwz};
  assign b_all = {b_frz, b_iff, b_idf, b_start, b_busy, b_cnt};

  pipeline_stall_controller #(.MEM_WAIT_CYCLES(1), .STALL_CNT_W(4)) dut_b (
    .clk(clk), .rst(b_rst), .hazard_detected(b_haz), .branch_taken(b_br),
    .mem_r_en_mem(b_mr), .mem_w_en_mem(b_mw), .stall_cnt_clr(b_clr),
    .pc_freeze(b_pc), .if_id_freeze(b_ifz), .if_id_flush(b_iff),
    .id_exe_freeze(b_idz), .id_exe_flush(b_idf), .exe_mem_freeze(b_emz),
    .mem_wb_freeze(b_mwz), .sram_start(b_start), .mem_busy(b_busy),
    .stall_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- reset with every input high ----
    a_rst = 0; a_haz = 1; a_br = 1; a_mr = 1; a_mw = 1; a_clr = 1;
    b_rst = 0; b_haz = 1; b_br = 1; b_mr = 1; b_mw = 1; b_clr = 1;
    #2;
    chk("a_reset_all", 32'(a_all), 32'h0);
    chk("b_reset_all", 32'(b_all), 32'h0);
    repeat (2) cyc();
    chk("a_reset_hold", 32'(a_all), 32'h0);

    a_haz = 0; a_br = 0; a_mr = 0; a_mw = 0; a_clr = 0; a_rst = 1;
    b_haz = 0; b_br = 0; b_mr = 0; b_mw = 0; b_clr = 0; b_rst = 1;
    @(negedge clk);
    chk("a_idle_after_rst", 32'(a_all), 32'h0);
    cyc();

    // ---- load wait: read held 5 cycles ----
    a_mr = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("load_frz_c%0d", c), 32'(a_frz), (c < 4) ? 32'h1f : 32'h0);
      chk($sformatf("load_start_c%0d", c), 32'(a_start), (c == 0) ? 32'h1 : 32'h0);
      chk($sformatf("load_busy_c%0d", c), 32'(a_busy), (c < 4) ? 32'h1 : 32'h0);
      chk($sformatf("load_flush_c%0d", c), 32'(a_fl), 32'h0);
      cyc();
    end
    a_mr = 0;
    @(negedge clk);
    chk("load_stall_cnt", 32'(a_cnt), 32'd4);
    chk("load_no_restart", 32'(a_start), 32'h0);
    cyc();

    // ---- branch during access (write access this time) ----
    a_mw = 1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) a_br = 1;
      @(negedge clk);
      chk($sformatf("brmem_flush_c%0d", c), 32'(a_fl), (c == 4) ? 32'h3 : 32'h0);
      chk($sformatf("brmem_frz_c%0d", c), 32'(a_frz), (c < 4) ? 32'h1f : 32'h0);
      chk($sformatf("brmem_start_c%0d", c), 32'(a_start), (c == 0) ? 32'h1 : 32'h0);
      cyc();
    end
    a_mw = 0; a_br = 0;

    // ---- branch + hazard in the same cycle ----
    a_br = 1; a_haz = 1;
    @(negedge clk);
    chk("brhz_flush", 32'(a_fl), 32'h3);
    chk("brhz_frz", 32'(a_frz), 32'h0);
    chk("brhz_cnt_before", 32'(a_cnt), 32'd8);
    cyc();

    // ---- hazard only ----
    a_br = 0; a_haz = 1;
    @(negedge clk);
    chk("brhz_cnt_unchanged", 32'(a_cnt), 32'd8);
    chk("hz_frz", 32'(a_frz), 32'h18);
    chk("hz_flush", 32'(a_fl), 32'h1);
    chk("hz_busy", 32'(a_busy), 32'h0);
    cyc();
    a_haz = 0;
    @(negedge clk);
    chk("hz_cnt", 32'(a_cnt), 32'd9);
    chk("hz_release", 32'(a_frz), 32'h0);
    cyc();

    // ---- back-to-back memory instructions ----
    a_mr = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_busy_c%0d", c), 32'(a_busy), (c % 5 != 4) ? 32'h1 : 32'h0);
      chk($sformatf("b2b_start_c%0d", c), 32'(a_start), (c % 5 == 0) ? 32'h1 : 32'h0);
      cyc();
    end
    a_mr = 0;
    @(negedge clk);
    chk("b2b_cnt", 32'(a_cnt), 32'd17);
    cyc();

    // ---- clear, with a hazard present to prove clear wins ----
    a_clr = 1; a_haz = 1;
    cyc();
    a_clr = 0; a_haz = 0;
    @(negedge clk);
    chk("clr_cnt", 32'(a_cnt), 32'd0);
    cyc();

    // ---- reset mid-access ----
    a_mr = 1;
    @(negedge clk);
    chk("mid_start", 32'(a_start), 32'h1);
    cyc();
    cyc();
    #2 a_rst = 0;
    #1;
    chk("mid_rst_all", 32'(a_all), 32'h0);
    cyc();
    a_rst = 1;
    @(negedge clk);
    chk("mid_restart_start", 32'(a_start), 32'h1);
    chk("mid_restart_frz", 32'(a_frz), 32'h1f);
    cyc();
    a_mr = 0;
    repeat (4) cyc();
    @(negedge clk);
    chk("mid_done_idle", 32'(a_frz), 32'h0);
    chk("mid_cnt", 32'(a_cnt), 32'd4);
    cyc();

    // ---- instance B: saturation ----
    b_haz = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 10 || c == 16 || c == 19)
        chk($sformatf("sat_c%0d", c), 32'(b_cnt), (c < 15) ? 32'(c) : 32'd15);
      cyc();
    end
    @(negedge clk);
    chk("sat_hold", 32'(b_cnt), 32'd15);
    cyc();
    b_haz = 0; b_clr = 1;
    cyc();
    b_clr = 0;
    @(negedge clk);
    chk("sat_clr", 32'(b_cnt), 32'd0);
    cyc();

    // ---- instance B: single-cycle memory access ----
    b_mr = 1;
    @(negedge clk);
    chk("w1_c0_frz", 32'(b_frz), 32'h1f);
    chk("w1_c0_start", 32'(b_start), 32'h1);
    cyc();
    @(negedge clk);
    chk("w1_c1_frz", 32'(b_frz), 32'h0);
    chk("w1_c1_busy", 32'(b_busy), 32'h0);
    chk("w1_c1_start", 32'(b_start), 32'h0);
    chk("w1_c1_cnt", 32'(b_cnt), 32'd1);
    cyc();
    b_mr = 0;
    @(negedge clk);
    chk("w1_idle", 32'(b_frz), 32'h0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central freeze/flush sequencer for the 5-stage ARM pipeline. It combines the hazard detection unit's `hazard_detected`, the EXE-stage `branch_taken`, and multi-cycle data-memory (SRAM) accesses into per-register freeze and flush controls. It owns the memory wait-state FSM and a saturating stall-cycle performance counter. It sits beside the pipeline registers in the top level and is the only driver of their freeze/flush inputs.

## Interface
Parameters:
- `MEM_WAIT_CYCLES`, 4: total freeze cycles per memory access; legal range 1..15.
- `STALL_CNT_W`, 16: width of the stall performance counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `hazard_detected`  in  1  from the hazard detection unit.
- `branch_taken`  in  1  EXE-stage branch resolved taken.
- `mem_r_en_mem`  in  1  MEM-stage instruction reads memory.
- `mem_w_en_mem`  in  1  MEM-stage instruction writes memory.
- `stall_cnt_clr`  in  1  synchronous clear of `stall_cnt`.
- `pc_freeze`  out  1  hold PC.
- `if_id_freeze`  out  1  hold IF/ID register.
- `if_id_flush`  out  1  load NOP into IF/ID.
- `id_exe_freeze`  out  1  hold ID/EXE register.
- `id_exe_flush`  out  1  load bubble into ID/EXE.
- `exe_mem_freeze`  out  1  hold EXE/MEM register.
- `mem_wb_freeze`  out  1  hold MEM/WB register.
- `sram_start`  out  1  one-cycle pulse starting the SRAM access.
- `mem_busy`  out  1  memory access in progress (pipeline globally frozen).
- `stall_cnt`  out  STALL_CNT_W  saturating count of cycles with `pc_freeze` high.

## Operation
Memory FSM states:
- **IDLE**
  - `mem_req = mem_r_en_mem | mem_w_en_mem`.
  - If `mem_req`: assert `sram_start` and `mem_busy` combinationally in this cycle, and load `wait_cnt <= MEM_WAIT_CYCLES-1`.
  - Next state is DONE if `MEM_WAIT_CYCLES == 1`, else ACCESS.
- **ACCESS**
  - `mem_busy` = 1.
  - If `wait_cnt == 1`, go to DONE; else decrement `wait_cnt`.
  - Lasts exactly `MEM_WAIT_CYCLES-1` cycles.
- **DONE**
  - `mem_busy` = 0. The pipeline advances at the end of this cycle.
  - The request is ignored here so the same instruction does not retrigger.
  - Always returns to IDLE.
  - A new MEM-stage request is evaluated in the following IDLE cycle.

Output priority, evaluated every cycle (highest first):
1. **`mem_busy`**: all five freeze outputs = 1; both flushes = 0. Branch and hazard are ignored; the frozen instructions re-present them after release.
2. **`branch_taken`**:
   - `if_id_flush` = 1 and `id_exe_flush` = 1.
   - All freezes = 0, so the PC loads the branch target.
   - A simultaneous `hazard_detected` is discarded, since its instruction is flushed.
3. **`hazard_detected`**:
   - `pc_freeze` = 1, `if_id_freeze` = 1, `id_exe_flush` = 1.
   - All other outputs = 0.
4. **Otherwise**: all freeze and flush outputs = 0.

Stall counter:
- Increments when `pc_freeze` = 1; saturates at all-ones.
- `stall_cnt_clr` wins over increment.

Widths: `wait_cnt` is 4 bits.

## Timing
- Reset (`rst` = 0, asynchronous):
  - State goes to IDLE; `wait_cnt` = 0; `stall_cnt` = 0.
  - Every output is forced to 0 while `rst` is low, regardless of inputs.
- Reset asserted mid-access aborts the access immediately. No `sram_start` is issued until the first IDLE cycle after release.
- Memory access latency:
  - Request visible in cycle T.
  - Freezes are high in cycles T .. T+MEM_WAIT_CYCLES-1.
  - DONE occurs in cycle T+MEM_WAIT_CYCLES, with freezes low.
  - `sram_start` is high only in cycle T.
- Back-to-back memory instructions:
  - Second request is seen at T+MEM_WAIT_CYCLES+1.
  - Exactly one unfrozen cycle separates the two freeze windows.
- Hazard and branch outputs are purely combinational from the current-cycle inputs and state. They add zero latency.

## Test plan
- **Reset**:
  - Stimulus: hold `rst` = 0 with all inputs = 1.
  - Required: every output = 0.
  - Stimulus: release `rst`, then assert `mem_r_en_mem`.
  - Required: `sram_start` pulses exactly once.
- **Load wait**, `MEM_WAIT_CYCLES` = 4:
  - Stimulus: `mem_r_en_mem` = 1 held for 5 cycles.
  - Required: freezes high for cycles 0–3 and low in cycle 4; `sram_start` high only in cycle 0; `stall_cnt` = 4.
- **Branch during access**:
  - Stimulus: `branch_taken` = 1 in cycle 2 of an access.
  - Required: no flush in cycles 0–3; in the DONE cycle (cycle 4), `if_id_flush` = `id_exe_flush` = 1.
- **Branch + hazard same cycle**:
  - Required: `if_id_flush` = `id_exe_flush` = 1, `pc_freeze` = 0, `stall_cnt` unchanged.
- **Hazard only**:
  - Required: `pc_freeze` = `if_id_freeze` = `id_exe_flush` = 1; `exe_mem_freeze` = `mem_wb_freeze` = 0.
- **Saturation / clear and `MEM_WAIT_CYCLES` = 1**:
  - Stimulus: with `STALL_CNT_W` = 4, hold `hazard_detected` for 20 cycles.
  - Required: `stall_cnt` = 15 and holds; `stall_cnt_clr` yields 0 in the next cycle.
  - Stimulus: with `MEM_WAIT_CYCLES` = 1, a single request.
  - Required: one frozen cycle, then DONE.
